gray_fifo_wptr_ctrl: RTL and testbench



---
 rtl/gray_fifo_wptr_ctrl.sv | 123 ++++++++++++
 tb/tb_gray_fifo_wptr_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_fifo_wptr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO: gray write pointer, RAM
// write port, read-pointer synchroniser and full / almost-full / level flags.
module gray_fifo_wptr_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LEVEL = 2**ADDR_W - 1
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_cg,
    input  logic              i_wrValid,
    output logic              o_wrReady,
    output logic              o_wrEn,
    output logic [ADDR_W-1:0] o_wrAddr,
    input  logic [ADDR_W:0]   i_rdGray,
    output logic [ADDR_W:0]   o_wrGray,
    output logic              o_full,
    output logic              o_afull,
    output logic [ADDR_W:0]   o_level
);

    localparam int PW = ADDR_W + 1;

    // Full when the write gray equals the synchronised read gray with its two
    // MSBs inverted (both bits when the pointer is only two bits wide).
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
    localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LEVEL);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PW-1:0]     wb_q, wb_d;
    logic [PW-1:0]     wg_q, wg_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              full_q, full_d;
    logic              afull_q, afull_d;
    logic [PW-1:0]     level_q, level_d;
    logic [PW-1:0]     sync_q [SYNC_STAGES];
    logic [PW-1:0]     sync_d [SYNC_STAGES];

    logic [PW-1:0]     rs;
    logic [PW-1:0]     rb;
    logic              acc;

    assign acc = i_wrValid & ~full_q & i_cg;

    // Synchroniser chain: stage 0 is the CDC capture flop; only the last
    // stage is ever consumed.
    always_comb begin
        // NOTE: every variable gets a default before any condition so no
        // path leaves it unassigned, which would infer a latch.
        sync_d = sync_q;
        if (i_cg) begin
            sync_d[0] = i_rdGray;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_d[k] = sync_q[k-1];
            end
        end
    end

    assign rs = sync_q[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        rb       = '0;
        rb[PW-1] = rs[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            rb[i] = rb[i+1] ^ rs[i];
        end
    end

    always_comb begin
        wb_d      = wb_q;
        wg_d      = wg_q;
        wr_addr_d = wr_addr_q;
        full_d    = full_q;
        afull_d   = afull_q;
        level_d   = level_q;
        if (i_cg) begin
            wb_d      = acc ? wb_q + PW'(1) : wb_q;
            wg_d      = bin2gray(wb_d);
            wr_addr_d = wb_d[ADDR_W-1:0];
            full_d    = (wg_d == (rs ^ FULL_MASK));
            level_d   = wb_d - rb;
            afull_d   = (level_d >= AFULL_THR);
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wb_q      <= '0;
            wg_q      <= '0;
            wr_addr_q <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            level_q   <= '0;
            // NOTE: the synchroniser array is reset like any other flop so a
            // stale read pointer can never survive a reset and fake a level.
            sync_q    <= '{default: '0};
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            wb_q      <= wb_d;
            wg_q      <= wg_d;
            wr_addr_q <= wr_addr_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            level_q   <= level_d;
            sync_q    <= sync_d;
        end
    end

    // The RAM strobe is killed while reset is low even though full_q is 0 then.
    assign o_wrEn    = acc & i_arst_n;
    assign o_wrReady = ~full_q;
    assign o_wrAddr  = wr_addr_q;
    assign o_wrGray  = wg_q;
    assign o_full    = full_q;
    assign o_afull   = afull_q;
    assign o_level   = level_q;

endmodule

// File: tb/tb_gray_fifo_wptr_ctrl.sv
// Self-checking bench for gray_fifo_wptr_ctrl: directed scenarios then random
// traffic, all compared against a count-based occupancy model.
module tb_gray_fifo_wptr_ctrl;

    localparam int ADDR_W      = 2;
    localparam int SYNC_STAGES = 2;
    localparam int AFULL_LEVEL = 3;
    localparam int DEPTH       = 1 << ADDR_W;
    localparam int MOD         = DEPTH * 2;

    logic              i_clk;
    logic              i_arst_n;
    logic              i_cg;
    logic              i_wrValid;
    logic              o_wrReady;
    logic              o_wrEn;
    logic [ADDR_W-1:0] o_wrAddr;
    logic [ADDR_W:0]   i_rdGray;
    logic [ADDR_W:0]   o_wrGray;
    logic              o_full;
    logic              o_afull;
    logic [ADDR_W:0]   o_level;

    gray_fifo_wptr_ctrl #(
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES),
        .AFULL_LEVEL (AFULL_LEVEL)
    ) dut (
        .i_clk     (i_clk),
        .i_arst_n  (i_arst_n),
        .i_cg      (i_cg),
        .i_wrValid (i_wrValid),
        .o_wrReady (o_wrReady),
        .o_wrEn    (o_wrEn),
        .o_wrAddr  (o_wrAddr),
        .i_rdGray  (i_rdGray),
        .o_wrGray  (o_wrGray),
        .o_full    (o_full),
        .o_afull   (o_afull),
        .o_level   (o_level)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: plain counts of accepted writes and of read-pointer advances.
    int m_wr;
    int m_level;
    bit m_full;
    bit m_afull;
    int m_sync[$];
    int rd_cnt;

    function automatic logic [ADDR_W:0] gray_of(input int n);
        int b;
        b = n % MOD;
        return (ADDR_W+1)'(b ^ (b >> 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr    = 0;
        m_level = 0;
        m_full  = 1'b0;
        m_afull = 1'b0;
        m_sync.delete();
        for (int k = 0; k < SYNC_STAGES; k++) m_sync.push_back(0);
    endtask

    task automatic model_edge(input logic valid, input logic cg, input int rd);
        int rs_cnt;
        int nxt;
        int lvl;
        if (!cg) return;
        rs_cnt = m_sync[$];
        nxt    = m_wr + ((valid && !m_full) ? 1 : 0);
        lvl    = (nxt - rs_cnt) % MOD;
        if (lvl < 0) lvl += MOD;
        m_level = lvl;
        m_full  = (lvl == DEPTH);
        m_afull = (lvl >= AFULL_LEVEL);
        m_sync.push_front(rd);
        void'(m_sync.pop_back());
        m_wr = nxt;
    endtask

    task automatic check_regs();
        check("wr_gray",  32'(o_wrGray),  32'(gray_of(m_wr)));
        check("wr_addr",  32'(o_wrAddr),  32'(m_wr % DEPTH));
        check("full",     32'(o_full),    32'(m_full));
        check("afull",    32'(o_afull),   32'(m_afull));
        check("level",    32'(o_level),   32'(m_level));
        check("wr_ready", 32'(o_wrReady), 32'(!m_full));
    endtask

    // One clock: drive at the falling edge, check the combinational strobe,
    // then check registered outputs just after the rising edge.
    task automatic step(input logic valid, input logic cg, input int rd);
        @(negedge i_clk);
        i_wrValid = valid;
        i_cg      = cg;
        rd_cnt    = rd;
        i_rdGray  = gray_of(rd);
        #1;
        check("wr_en", 32'(o_wrEn), 32'(valid && cg && !m_full));
        @(posedge i_clk);
        model_edge(valid, cg, rd);
        #1;
        check_regs();
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        #2;
        i_arst_n = 1'b0;
        #1;
        check("rst_wr_gray",  32'(o_wrGray),  32'd0);
        check("rst_wr_addr",  32'(o_wrAddr),  32'd0);
        check("rst_full",     32'(o_full),    32'd0);
        check("rst_afull",    32'(o_afull),   32'd0);
        check("rst_level",    32'(o_level),   32'd0);
        check("rst_wr_ready", 32'(o_wrReady), 32'd1);
        check("rst_wr_en",    32'(o_wrEn),    32'd0);
        model_reset();
        rd_cnt   = 0;
        i_rdGray = '0;
        @(posedge i_clk);
        #1;
        check_regs();
        check("rst_wr_en_edge", 32'(o_wrEn), 32'd0);
        i_wrValid = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge i_clk);
        #2;
        i_arst_n = 1'b1;
        @(posedge i_clk);
        model_edge(i_wrValid, i_cg, rd_cnt);
        #1;
        check_regs();
    endtask

    // The synchronised read pointer may move by at most one gray bit per edge.
    logic [ADDR_W:0] rs_prev = '0;
    always @(negedge i_clk) begin
        if (!i_arst_n) begin
            rs_prev = '0;
        end else begin
            n_cmp++;
            assert ($countones(dut.rs ^ rs_prev) <= 1) else begin
                n_fail++;
                $error("FAIL rs_gray_step: observed %0h after %0h, required at most one bit change",
                       dut.rs, rs_prev);
            end
            rs_prev = dut.rs;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within its time limit");
        $fatal(1, "watchdog expired");
    end

    logic [ADDR_W:0] t1_gray [4];
    int              n_wrap;
    int              n_g100;
    logic            r_valid;
    logic            r_cg;
    int              r_rd;

    initial begin
        t1_gray   = '{3'b001, 3'b011, 3'b010, 3'b110};
        i_arst_n  = 1'b1;
        i_cg      = 1'b1;
        i_wrValid = 1'b0;
        i_rdGray  = '0;
        rd_cnt    = 0;
        model_reset();

        do_reset();
        release_reset();

        // Fill from empty: almost-full on the 3rd accept, full on the 4th,
        // then two refused cycles.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 0);
            if (i < 4) begin
                check("t1_gray", 32'(o_wrGray), 32'(t1_gray[i]));
                check("t1_addr", 32'(o_wrAddr), 32'((i + 1) % DEPTH));
            end
            if (i == 2) begin
                check("t3_afull_rise", 32'(o_afull), 32'd1);
                check("t3_not_full",   32'(o_full),  32'd0);
            end
            if (i == 3) begin
                check("t1_full",  32'(o_full),  32'd1);
                check("t1_level", 32'(o_level), 32'd4);
            end
        end

        // One read: full clears exactly SYNC_STAGES+1 edges later.
        for (int k = 0; k < SYNC_STAGES + 1; k++) begin
            step(1'b0, 1'b1, 1);
            if (k < SYNC_STAGES) check("t2_full_hold", 32'(o_full), 32'd1);
        end
        check("t2_full_clear", 32'(o_full),  32'd0);
        check("t2_level",      32'(o_level), 32'd3);
        step(1'b1, 1'b1, 1);
        check("t2_refull", 32'(o_full), 32'd1);
        step(1'b1, 1'b1, 1);

        // Drain to one behind the writer, then stream with a trailing reader.
        for (int r = 2; r <= 4; r++) step(1'b0, 1'b1, r);
        step(1'b0, 1'b1, 4);
        step(1'b0, 1'b1, 4);
        n_wrap = 0;
        n_g100 = 0;
        for (int w = 0; w < 20; w++) begin
            step(1'b1, 1'b1, m_wr - 1);
            if (o_wrGray == 3'b000) n_wrap++;
            if (o_wrGray == 3'b100) n_g100++;
            check("t4_no_full",     32'(o_full), 32'd0);
            check("t4_level_range", 32'(o_level >= 1 && o_level <= 2), 32'd1);
            for (int j = 0; j < 2; j++) begin
                step(1'b0, 1'b1, m_wr - 1);
                check("t4_level_range_idle", 32'(o_level >= 1 && o_level <= 2), 32'd1);
            end
        end
        check("t4_wraps",   32'(n_wrap), 32'd3);
        check("t4_gray100", 32'(n_g100), 32'd3);

        // Clock gate low: nothing moves even though the read pointer does.
        step(1'b0, 1'b1, 24);
        check("t5_pre_level", 32'(o_level), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 25);
            check("t5_frozen_gray",  32'(o_wrGray), 32'(gray_of(25)));
            check("t5_frozen_level", 32'(o_level),  32'd1);
        end
        for (int k = 0; k < SYNC_STAGES + 1; k++) begin
            step(1'b0, 1'b1, 25);
            if (k < SYNC_STAGES) check("t5_level_wait", 32'(o_level), 32'd1);
        end
        check("t5_level_update", 32'(o_level), 32'd0);

        // Reset with three words in flight and a write pending.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 25);
        check("t6_level3", 32'(o_level), 32'd3);
        i_wrValid = 1'b1;
        do_reset();
        release_reset();
        check("t6_first_addr", 32'(o_wrAddr), 32'd0);
        step(1'b1, 1'b1, 0);
        check("t6_after_write", 32'(o_wrAddr), 32'd1);

        // Random traffic with a slower, gray-disciplined reader.
        for (int c = 0; c < 400; c++) begin
            r_valid = ($urandom % 4) != 0;
            r_cg    = ($urandom % 8) != 0;
            r_rd    = rd_cnt;
            if (r_cg && r_rd < m_wr && ($urandom % 3) == 0) r_rd++;
            step(r_valid, r_cg, r_rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
